parallel_serializer: RTL and testbench

Parallel-to-serial transmitter for the autocorrelation datapath: the transmit end of the 3-bit-word serial bit stream. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per `clk`, MSB first, with frame markers so the receiving deserializer can align. Consecutive words stream back-to-back with no idle bit between them.

---
 rtl/serializer_pkg.sv | 19 +
 rtl/parallel_serializer.sv | 137 +++++++++++++
 tb/tb_parallel_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serializer_pkg
//  Purpose  : Shared types and limits for the parallel_serializer block.
//             - ser_state_t : frame state (IDLE / SHIFT)
//             - MAX_WIDTH   : upper bound on the serializer WIDTH parameter
//  Revision : 1.0  initial release
// ============================================================================
package serializer_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/parallel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_serializer
//  Purpose  : Parallel-to-serial transmitter. Accepts WIDTH-bit words over a
//             valid/ready handshake and emits one bit per clock, MSB first,
//             with frame_start / frame_end markers. Back-to-back words are
//             streamed with no idle bit between frames.
//  Ports    : clk          - clock, rising edge
//             rst          - synchronous active-high reset
//             data_in      - parallel word, sampled on load_valid && load_ready
//             load_valid   - upstream word available
//             load_ready   - word accepted this cycle when load_valid is high
//             out          - registered serial bit
//             out_valid    - out carries a frame bit
//             frame_start  - first (MSB) bit of a frame
//             frame_end    - last bit of a frame
//  Config   : PARALLEL_SERIALIZER_PARITY_EN - when defined, an even-parity
//             bit (XOR of the accepted word) follows the data bits and
//             carries frame_end.
//  Revision : 1.0  initial release
// ============================================================================
module parallel_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_end
);

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);

    localparam logic [0:0]    c_ST_IDLE  = IDLE;
    localparam logic [0:0]    c_ST_SHIFT = SHIFT;
    localparam logic [CW-1:0] c_CNT_FULL = CW'(FLEN);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_CNT_TWO  = CW'(2);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
            $error("parallel_serializer: WIDTH out of range 2..32");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;   // bits still to be placed on out, MSB next
    logic [CW-1:0]    r_cnt;     // bits remaining, including the one on out
    logic             r_out;
    logic             r_out_valid;
    logic             r_frame_start;
    logic             r_frame_end;
    logic             w_last;
    logic             w_accept;
    logic             w_next_bit;

    // r_cnt == 1 means the bit currently on out is the final bit of the frame
    assign w_last     = (r_state == c_ST_SHIFT) && (r_cnt == c_CNT_ONE);
    assign load_ready = !rst && ((r_state == c_ST_IDLE) || w_last);
    assign w_accept   = load_valid && load_ready;

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    logic r_parity;

    // Parity is captured at accept; it takes the final slot of the frame
    assign w_next_bit = (r_cnt == c_CNT_TWO) ? r_parity : r_shift[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end
`else
    assign w_next_bit = r_shift[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_out         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else if (w_accept) begin
            // MSB goes straight to out; the remainder waits in r_shift
            r_state       <= c_ST_SHIFT;
            r_shift       <= data_in << 1;
            r_cnt         <= c_CNT_FULL;
            r_out         <= data_in[WIDTH-1];
            r_out_valid   <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_end   <= 1'b0;
        end else if (r_state == c_ST_SHIFT) begin
            r_frame_start <= 1'b0;
            if (r_cnt == c_CNT_ONE) begin
                r_state     <= c_ST_IDLE;
                r_shift     <= '0;
                r_cnt       <= '0;
                r_out       <= 1'b0;
                r_out_valid <= 1'b0;
                r_frame_end <= 1'b0;
            end else begin
                r_shift     <= r_shift << 1;
                r_cnt       <= r_cnt - c_CNT_ONE;
                r_out       <= w_next_bit;
                r_frame_end <= (r_cnt == c_CNT_TWO);
            end
        end else begin
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_out         <= 1'b0;
            r_out_valid   <= 1'b0;
        end
    end

    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

endmodule : parallel_serializer
`default_nettype wire

// File: tb/tb_parallel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parallel_serializer
//  Purpose  : Directed self-checking bench for parallel_serializer (WIDTH=3).
//             Inputs change 1 time unit after a rising edge; outputs are
//             checked at the same point, i.e. they reflect the cycle that
//             follows that edge.
//  Config   : PARALLEL_SERIALIZER_PARITY_EN selects the parity frame vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parallel_serializer;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             frame_start;
    logic             frame_end;

    int n_cmp = 0;
    int n_err = 0;

    parallel_serializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks every output of the current cycle against hand-computed values
    task automatic chk(input string tag, input logic e_out, input logic e_ov,
                       input logic e_fs, input logic e_fe, input logic e_lr);
        chk1({tag, ".out"},         out,         e_out);
        chk1({tag, ".out_valid"},   out_valid,   e_ov);
        chk1({tag, ".frame_start"}, frame_start, e_fs);
        chk1({tag, ".frame_end"},   frame_end,   e_fe);
        chk1({tag, ".load_ready"},  load_ready,  e_lr);
    endtask

    initial begin
        // ---------------- reset with load_valid held high ----------------
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 3'b111;
        tick(); chk("rst_c1", 0, 0, 0, 0, 0);
        tick(); chk("rst_c2", 0, 0, 0, 0, 0);
        tick(); chk("rst_c3", 0, 0, 0, 0, 0);
        rst        = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("post_rst_idle", 0, 0, 0, 0, 1);
        tick(); chk("idle_no_accept", 0, 0, 0, 0, 1);

`ifdef PARALLEL_SERIALIZER_PARITY_EN
        // ---------------- 3'b110 -> 1,1,0,parity 0 ----------------
        data_in = 3'b110; load_valid = 1'b1;
        tick(); chk("p110_b0", 1, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("p110_b1", 1, 1, 0, 0, 0);
        tick(); chk("p110_b2", 0, 1, 0, 0, 0);
        tick(); chk("p110_par", 0, 1, 0, 1, 1);
        tick(); chk("p110_idle", 0, 0, 0, 0, 1);

        // ------- 3'b100 -> 1,0,0,1 then back-to-back 3'b011 -> 0,1,1,0 -------
        data_in = 3'b100; load_valid = 1'b1;
        tick(); chk("p100_b0", 1, 1, 1, 0, 0);
        data_in = 3'b011;
        tick(); chk("p100_b1", 0, 1, 0, 0, 0);
        tick(); chk("p100_b2", 0, 1, 0, 0, 0);
        tick(); chk("p100_par", 1, 1, 0, 1, 1);
        tick(); chk("p011_b0", 0, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("p011_b1", 1, 1, 0, 0, 0);
        tick(); chk("p011_b2", 1, 1, 0, 0, 0);
        tick(); chk("p011_par", 0, 1, 0, 1, 1);
        tick(); chk("p011_idle", 0, 0, 0, 0, 1);
`else
        // ---------------- single word 3'b110 ----------------
        data_in = 3'b110; load_valid = 1'b1;
        tick(); chk("s110_b0", 1, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("s110_b1", 1, 1, 0, 0, 0);
        tick(); chk("s110_b2", 0, 1, 0, 1, 1);
        tick(); chk("s110_idle", 0, 0, 0, 0, 1);

        // ---------------- back-to-back 3'b101, 3'b011 ----------------
        data_in = 3'b101; load_valid = 1'b1;
        tick(); chk("b2b_w0_b0", 1, 1, 1, 0, 0);
        data_in = 3'b011;
        tick(); chk("b2b_w0_b1", 0, 1, 0, 0, 0);
        tick(); chk("b2b_w0_b2", 1, 1, 0, 1, 1);
        tick(); chk("b2b_w1_b0", 0, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("b2b_w1_b1", 1, 1, 0, 0, 0);
        tick(); chk("b2b_w1_b2", 1, 1, 0, 1, 1);
        tick(); chk("b2b_idle", 0, 0, 0, 0, 1);

        // ------- mid-frame load_valid with changing data_in is ignored -------
        data_in = 3'b100; load_valid = 1'b1;
        tick(); chk("mid_b0", 1, 1, 1, 0, 0);
        data_in = 3'b011;
        tick(); chk("mid_b1", 0, 1, 0, 0, 0);
        data_in = 3'b111; load_valid = 1'b0;
        tick(); chk("mid_b2", 0, 1, 0, 1, 1);
        tick(); chk("mid_idle", 0, 0, 0, 0, 1);
`endif

        // ---------------- reset during a frame of 3'b111 ----------------
        data_in = 3'b111; load_valid = 1'b1;
        tick(); chk("rmid_b0", 1, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("rmid_b1", 1, 1, 0, 0, 0);
        rst = 1'b1;
        tick(); chk("rmid_in_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rmid_released", 0, 0, 0, 0, 1);

        // ---------------- clean frame 3'b010 after reset ----------------
        data_in = 3'b010; load_valid = 1'b1;
        tick(); chk("r010_b0", 0, 1, 1, 0, 0);
        load_valid = 1'b0;
        tick(); chk("r010_b1", 1, 1, 0, 0, 0);
`ifdef PARALLEL_SERIALIZER_PARITY_EN
        tick(); chk("r010_b2", 0, 1, 0, 0, 0);
        tick(); chk("r010_par", 1, 1, 0, 1, 1);
`else
        tick(); chk("r010_b2", 0, 1, 0, 1, 1);
`endif
        tick(); chk("r010_idle", 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_parallel_serializer
`default_nettype wire
